line_window_3x3: RTL and testbench

LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

---
 rtl/line_window_3x3.sv | 133 +++++++++++++
 tb/tb_line_window_3x3.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_3x3.sv
// 3x3 sliding-window generator for a raster pixel stream.
// Two line memories hold the previous two lines. A 3x3 register window shifts
// one column per accepted pixel. Windows are emitted only when fully inside the
// image (no border padding), through a single output register. The output
// register back-pressures the input directly.
module line_window_3x3 #(
    parameter int DATA_W     = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     pixel_in,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic [9*DATA_W-1:0]   window_out,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    // Handshake: a transfer happens on a side when its valid and ready are both
    // high at a rising edge. in_ready is combinational from the output register
    // (no skid buffer), so the input stalls exactly while a window is held.

    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    eff_col;
    logic [ROW_W-1:0]    eff_row;
    logic                in_fire;
    logic                emit;
    logic                at_last;
    logic [DATA_W-1:0]   lb0 [IMG_WIDTH];
    logic [DATA_W-1:0]   lb1 [IMG_WIDTH];
    logic [DATA_W-1:0]   win [3][3];
    logic [DATA_W-1:0]   col_top;
    logic [DATA_W-1:0]   col_mid;
    logic [9*DATA_W-1:0] next_window;

    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;

    // A start-of-frame pixel is forced to position (0,0) whatever the counters say.
    assign eff_col = in_sof ? '0 : col;
    assign eff_row = in_sof ? '0 : row;

    // Line memories are read-before-write at the same column.
    assign col_top = lb1[eff_col];
    assign col_mid = lb0[eff_col];

    // Only positions with two lines and two columns of history form a window.
    assign emit    = (eff_row >= ROW_W'(2)) && (eff_col >= COL_W'(2));
    assign at_last = (eff_row == ROW_LAST) && (eff_col == COL_LAST);

    // Window as it will look after this pixel shifts in, packed row-major.
    always_comb begin
        next_window = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                next_window[DATA_W*(3*r+c) +: DATA_W] = win[r][c+1];
            end
        end
        next_window[DATA_W*2 +: DATA_W] = col_top;
        next_window[DATA_W*5 +: DATA_W] = col_mid;
        next_window[DATA_W*8 +: DATA_W] = pixel_in;
    end

    // Raster position counters, advanced once per accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_fire) begin
            if (eff_col == COL_LAST) begin
                col <= '0;
                row <= (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
            end else begin
                col <= eff_col + COL_W'(1);
                row <= eff_row;
            end
        end
    end

    // Line memories: the older line receives what the newer line held.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            lb1[eff_col] <= lb0[eff_col];
            lb0[eff_col] <= pixel_in;
        end
    end

    // 3x3 register window shifts one column left per accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (in_fire) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= col_top;
            win[1][2] <= col_mid;
            win[2][2] <= pixel_in;
        end
    end

    // Output register: load a new window, or drop the held one once taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_out <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else if (in_fire && emit) begin
            window_out <= next_window;
            out_valid  <= 1'b1;
            out_last   <= at_last;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_window_3x3.sv
// Testbench for line_window_3x3 with a 4x4 image. A reference model keeps the
// whole frame as a 2D image and cuts expected windows directly from it.
module tb_line_window_3x3;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WW = 9 * DW;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] pixel_in;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic [WW-1:0] window_out;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;

    line_window_3x3 #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready), .window_out(window_out),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // counters
    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;

    // reference model: frame image plus expected window queue
    logic [DW-1:0] img [H][W];
    int            m_row = 0;
    int            m_col = 0;
    logic [WW-1:0] exp_q[$];
    logic          exp_last_q[$];

    // monitor results
    logic [WW-1:0] got_q[$];
    logic          got_last_q[$];
    int            ready_err = 0;

    bit rand_ready = 0;

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_xfer(input logic [DW-1:0] v, input bit sof);
        logic [WW-1:0] w;
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = v;
        if (m_row >= 2 && m_col >= 2) begin
            w = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[DW*(3*r+c) +: DW] = img[m_row-2+r][m_col-2+c];
            exp_q.push_back(w);
            exp_last_q.push_back(m_row == H-1 && m_col == W-1);
        end
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            m_row++;
            if (m_row == H) m_row = 0;
        end
    endtask

    // Window of an image whose pixel (r,c) holds base + r*W + c, centred at (cr,cc).
    function automatic logic [WW-1:0] ramp_win(input int base, input int cr, input int cc);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[DW*(3*r+c) +: DW] = DW'(base + (cr-1+r)*W + (cc-1+c));
        return w;
    endfunction

    // monitor: records output transfers and the in_ready rule, mid-cycle
    always begin
        @(negedge clk);
        #3;
        if (rst_n) begin
            if (in_ready !== (!out_valid || out_ready)) ready_err++;
            if (out_valid && out_ready) begin
                got_q.push_back(window_out);
                got_last_q.push_back(out_last);
            end
        end
    end

    // driver tasks (called at a falling edge, return at a falling edge)
    task automatic send(input logic [DW-1:0] v, input bit sof);
        bit done;
        done     = 0;
        pixel_in = v;
        in_sof   = sof;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_ready) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        if (done) begin
            model_xfer(v, sof);
            @(negedge clk);
        end else begin
            check("send_timeout", 1, 0);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic drain(input int g0, input int e0);
        rand_ready = 0;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (got_q.size() - g0 >= exp_q.size() - e0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    // scoreboard: compare received windows against the model from given marks
    task automatic compare(input string tag, input int g0, input int e0);
        int ng, ne;
        ng = got_q.size() - g0;
        ne = exp_q.size() - e0;
        check({tag, "_count_vs_model"}, ng, ne);
        for (int i = 0; i < ng && i < ne; i++) begin
            check({tag, "_window"}, got_q[g0+i], exp_q[e0+i]);
            check({tag, "_last"}, got_last_q[g0+i], exp_last_q[e0+i]);
        end
    endtask

    task automatic stream_ramp(input int base, input bit first_sof);
        for (int i = 0; i < W*H; i++) send(DW'(base + i), first_sof && i == 0);
    endtask

    initial begin
        int g0, e0, nlast, sof_at;
        rst_n = 1'b0; pixel_in = '0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_window", window_out, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // single frame 0..15, always ready
        g0 = got_q.size(); e0 = exp_q.size();
        stream_ramp(0, 1);
        drain(g0, e0);
        compare("frame1", g0, e0);
        check("frame1_count", got_q.size() - g0, 4);
        if (got_q.size() - g0 >= 4) begin
            check("frame1_first", got_q[g0], ramp_win(0, 1, 1));
            check("frame1_last_win", got_q[g0+3], ramp_win(0, 2, 2));
            nlast = 0;
            for (int i = 0; i < 4; i++) nlast += int'(got_last_q[g0+i]);
            check("frame1_last_only_once", nlast, 1);
            check("frame1_last_on_final", got_last_q[g0+3], 1);
        end

        // stall: hold out_ready low once the first window appears
        g0 = got_q.size(); e0 = exp_q.size();
        for (int i = 0; i < 11; i++) send(DW'(i), i == 0);
        out_ready = 1'b0;
        pixel_in  = DW'(11);
        in_valid  = 1'b1;
        #1;
        check("stall_valid_set", out_valid, 1);
        check("stall_first_window", window_out, ramp_win(0, 1, 1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_window_hold", window_out, ramp_win(0, 1, 1));
            check("stall_last_hold", out_last, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 11; i < W*H; i++) send(DW'(i), 0);
        drain(g0, e0);
        compare("stall", g0, e0);
        check("stall_count", got_q.size() - g0, 4);

        // back-to-back frames
        g0 = got_q.size(); e0 = exp_q.size();
        stream_ramp(0, 1);
        stream_ramp(100, 1);
        drain(g0, e0);
        compare("b2b", g0, e0);
        check("b2b_count", got_q.size() - g0, 8);
        if (got_q.size() - g0 >= 5) check("b2b_second_first", got_q[g0+4], ramp_win(100, 1, 1));

        // mid-frame start of frame abandons the partial frame
        g0 = got_q.size(); e0 = exp_q.size();
        for (int i = 0; i < 6; i++) send(DW'(i), i == 0);
        stream_ramp(200, 1);
        drain(g0, e0);
        compare("midsof", g0, e0);
        check("midsof_count", got_q.size() - g0, 4);
        if (got_q.size() - g0 >= 4) begin
            check("midsof_first", got_q[g0], ramp_win(200, 1, 1));
            check("midsof_last", got_q[g0+3], ramp_win(200, 2, 2));
        end

        // reset asserted while a window is held
        for (int i = 0; i < 11; i++) send(DW'(i), i == 0);
        out_ready = 1'b0;
        @(negedge clk);
        check("prerst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_window", window_out, 0);
        exp_q.delete();
        exp_last_q.delete();
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        g0 = got_q.size(); e0 = exp_q.size();
        stream_ramp(0, 0);
        drain(g0, e0);
        compare("postrst", g0, e0);
        check("postrst_count", got_q.size() - g0, 4);
        if (got_q.size() - g0 >= 4) begin
            check("postrst_first", got_q[g0], ramp_win(0, 1, 1));
            check("postrst_last_win", got_q[g0+3], ramp_win(0, 2, 2));
            check("postrst_last_flag", got_last_q[g0+3], 1);
        end

        // randomized frames, random gaps and random downstream back-pressure
        g0 = got_q.size(); e0 = exp_q.size();
        rand_ready = 1;
        for (int f = 0; f < 4; f++) begin
            sof_at = (f == 2) ? int'($urandom_range(3, 12)) : W*H;
            for (int i = 0; i < W*H; i++) begin
                if (i == sof_at) break;
                send(DW'($urandom), i == 0);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            end
        end
        drain(g0, e0);
        compare("random", g0, e0);

        check("in_ready_rule", ready_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
